// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg: shared types and constants for the SPI image loader.
//   loader_state_t - frame FSM states
//   CMD_PREFIX     - upper nibble every valid command byte must carry
//   ERR_*          - bit positions inside the sticky err_o vector
package spi_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    FLUSH,
    ABORT
  } loader_state_t;

  localparam logic [3:0] CMD_PREFIX = 4'hB;

  localparam int unsigned ERR_BADCMD  = 0;
  localparam int unsigned ERR_PARTIAL = 1;
  localparam int unsigned ERR_OVERRUN = 2;

endpackage

// File: rtl/spi_loader_rx.sv
// spi_loader_rx: oversampling SPI mode-0 receiver in the clk_i domain.
// Synchronises sck/sdi/csb, detects sck rising edges and assembles LSB-first bytes.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   sck_i, sdi_i, csb_i asynchronous SPI pad inputs
//   csb_low_o           synchronised chip select is asserted
//   csb_fall_o/rise_o   one-cycle pulses on synchronised csb edges
//   byte_valid_o        one-cycle pulse, byte_o holds a completed byte
//   bit_nz_o            a byte is partially shifted in
module spi_loader_rx
  import spi_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       sdi_i,
  input  logic       csb_i,
  output logic       csb_low_o,
  output logic       csb_fall_o,
  output logic       csb_rise_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       bit_nz_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, csb_sync_q;
  logic                   sck_prev_q, csb_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             byte_q;
  logic                   byte_valid_q;

  logic sck_s, sdi_s, csb_s, sample;

  // Oldest stage is the synchronised value.
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign csb_s  = csb_sync_q[SYNC_STAGES-1];
  assign sample = sck_s & ~sck_prev_q & ~csb_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      csb_sync_q   <= '0;
      sck_prev_q   <= 1'b0;
      csb_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q   <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      csb_sync_q   <= {csb_sync_q[SYNC_STAGES-2:0], csb_i};
      sck_prev_q   <= sck_s;
      csb_prev_q   <= csb_s;
      byte_valid_q <= 1'b0;
      if (csb_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sample) begin
        // Shift in from the top so the first bit ends up in bit 0.
        shift_q   <= {sdi_s, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q       <= {sdi_s, shift_q[7:1]};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  assign csb_low_o    = ~csb_s;
  assign csb_fall_o   = csb_prev_q & ~csb_s;
  assign csb_rise_o   = ~csb_prev_q & csb_s;
  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign bit_nz_o     = (bit_cnt_q != 3'd0);

endmodule

// File: rtl/spi_loader.sv
// spi_loader: SPI-slave image loader. Decodes a command byte selecting a target,
// a little-endian start address, then streams DATA_WIDTH words over a valid/ready port.
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   sck_i, sdi_i, csb_i   asynchronous SPI mode-0 inputs (LSB-first bytes)
//   tgt_o, addr_o,        selected target, write word address,
//   wdata_o, wvalid_o,    write data and request,
//   wready_i              target accepts the write
//   busy_o                frame in progress or write pending
//   reset_req_o           hold cores in reset while loading
//   done_o                one-cycle pulse on a clean frame end
//   err_o                 sticky {overrun, partial, bad_cmd}
//   checksum_o            sum of accepted words when SPI_LOADER_CHECKSUM_EN is defined, else 0
module spi_loader
#(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_TGT     = 2,
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  sdi_i,
  input  logic                  csb_i,
  output logic [TGT_W-1:0]      tgt_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic                  busy_o,
  output logic                  reset_req_o,
  output logic                  done_o,
  output logic [2:0]            err_o,
  output logic [31:0]           checksum_o
);
  import spi_loader_pkg::*;

  localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
  localparam int unsigned ASM_W = (DATA_WIDTH > ADDR_BYTES * 8) ? DATA_WIDTH : ADDR_BYTES * 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_WORD_BYTE = CNT_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_ADDR_BYTE = CNT_W'(ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       csb_low, csb_fall, csb_rise, rx_valid, rx_bit_nz;
  logic [7:0] rx_byte;

  spi_loader_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sck_i       (sck_i),
    .sdi_i       (sdi_i),
    .csb_i       (csb_i),
    .csb_low_o   (csb_low),
    .csb_fall_o  (csb_fall),
    .csb_rise_o  (csb_rise),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .bit_nz_o    (rx_bit_nz)
  );

  loader_state_t         state_q, state_d;
  logic [TGT_W-1:0]      tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  busy_q, busy_d;
  logic                  reset_req_q, reset_req_d;
  logic                  done_q, done_d;
  logic [2:0]            err_q, err_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]      asm_q, asm_d;
  // A frame started while still flushing; its leading bits are lost.
  logic                  late_q, late_d;

  logic accept, cmd_ok, addr_last, word_done, flush_done, frame_start;

  assign accept      = wvalid_q & wready_i;
  assign cmd_ok      = (rx_byte[7:4] == CMD_PREFIX) && (32'(rx_byte[3:0]) < NUM_TGT);
  assign addr_last   = rx_valid && (byte_cnt_q == LAST_ADDR_BYTE);
  assign word_done   = rx_valid && (byte_cnt_q == LAST_WORD_BYTE);
  assign flush_done  = ~wvalid_q | accept;
  assign frame_start = (state_q == IDLE) && (csb_fall || (late_q && csb_low));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      addr_reg_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      reset_req_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_reg_q  <= addr_reg_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      busy_q      <= busy_d;
      reset_req_q <= reset_req_d;
      done_q      <= done_d;
      err_q       <= err_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      late_q      <= late_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (csb_fall)         state_d = CMD;
        else if (frame_start) state_d = ABORT;
      end
      CMD: begin
        if (csb_rise)      state_d = IDLE;
        else if (rx_valid) state_d = cmd_ok ? ADDR : ABORT;
      end
      ADDR: begin
        if (csb_rise)       state_d = IDLE;
        else if (addr_last) state_d = DATA;
      end
      DATA:  if (csb_rise)   state_d = FLUSH;
      FLUSH: if (flush_done) state_d = IDLE;
      ABORT: if (csb_rise)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_d       = tgt_q;
    addr_reg_d  = addr_reg_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q & ~accept;
    busy_d      = busy_q;
    reset_req_d = reset_req_q;
    done_d      = 1'b0;
    err_d       = err_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    late_d      = late_q;
    unique case (state_q)
      IDLE: begin
        late_d = 1'b0;
        if (frame_start) begin
          err_d      = '0;
          byte_cnt_d = '0;
          busy_d     = 1'b1;
          if (!csb_fall) err_d[ERR_BADCMD] = 1'b1;
        end
      end
      CMD: begin
        if (csb_rise) begin
          err_d[ERR_PARTIAL] = 1'b1;
          busy_d             = 1'b0;
          reset_req_d        = 1'b0;
        end else if (rx_valid) begin
          if (cmd_ok) begin
            tgt_d       = rx_byte[TGT_W-1:0];
            reset_req_d = 1'b1;
            byte_cnt_d  = '0;
          end else begin
            err_d[ERR_BADCMD] = 1'b1;
          end
        end
      end
      ADDR: begin
        if (csb_rise) begin
          err_d[ERR_PARTIAL] = 1'b1;
          busy_d             = 1'b0;
          reset_req_d        = 1'b0;
          byte_cnt_d         = '0;
        end else if (rx_valid) begin
          asm_d[8*int'(byte_cnt_q) +: 8] = rx_byte;
          if (addr_last) begin
            addr_reg_d = asm_d[ADDR_WIDTH-1:0];
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_d[8*int'(byte_cnt_q) +: 8] = rx_byte;
          if (word_done) begin
            byte_cnt_d = '0;
            // Acceptance in this same cycle frees the slot, so no bubble.
            if (flush_done) begin
              wdata_d    = asm_d[DATA_WIDTH-1:0];
              addr_d     = addr_reg_q;
              wvalid_d   = 1'b1;
              addr_reg_d = addr_reg_q + ADDR_WIDTH'(1);
            end else begin
              err_d[ERR_OVERRUN] = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_ONE;
          end
        end
        if (csb_rise) begin
          if (rx_bit_nz || (byte_cnt_d != '0)) err_d[ERR_PARTIAL] = 1'b1;
          byte_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (csb_fall) late_d = 1'b1;
        if (flush_done) begin
          busy_d      = 1'b0;
          reset_req_d = 1'b0;
          done_d      = (err_q == 3'b000);
        end
      end
      ABORT: if (csb_rise) busy_d = 1'b0;
      default: ;
    endcase
  end

`ifdef SPI_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (frame_start)  checksum_d = 32'd0;
    else if (accept)  checksum_d = checksum_q + 32'(wdata_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) checksum_q <= 32'd0;
    else       checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'd0;
`endif

  assign tgt_o       = tgt_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign wvalid_o    = wvalid_q;
  assign busy_o      = busy_q;
  assign reset_req_o = reset_req_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_spi_loader.sv
// tb_spi_loader: self-checking bench for spi_loader with default parameters.
// Drives SPI frames bit-banged at 1/6 of the system clock, collects accepted
// writes and compares them with a frame-level reference model.
module tb_spi_loader;

  logic        clk = 1'b0;
  logic        rst_i, sck, sdi, csb, wready;
  logic [0:0]  tgt_o;
  logic [12:0] addr_o;
  logic [31:0] wdata_o;
  logic        wvalid_o, busy_o, reset_req_o, done_o;
  logic [2:0]  err_o;
  logic [31:0] checksum_o;

  spi_loader dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sck_i      (sck),
    .sdi_i      (sdi),
    .csb_i      (csb),
    .tgt_o      (tgt_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready),
    .busy_o     (busy_o),
    .reset_req_o(reset_req_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .checksum_o (checksum_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [0:0]  tgt;
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         obs_q[$];
  logic [31:0] words[$];
  int          ready_mode = 1;  // 0 low, 1 high, 2 random
  int          done_cnt = 0;
  bit          rr_seen = 1'b0;

  // Sole driver of wready, changed just after each active edge.
  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) wready = 1'($urandom_range(0, 1));
      else                 wready = (ready_mode == 1);
    end
  end

  // Write monitor: records accepted writes and checks held requests stay stable.
  bit          prev_v = 1'b0, prev_acc = 1'b0;
  logic [12:0] prev_a;
  logic [31:0] prev_d;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_v   = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (reset_req_o) rr_seen = 1'b1;
      if (done_o) done_cnt++;
      if (wvalid_o && prev_v && !prev_acc) begin
        checks++;
        if (addr_o !== prev_a || wdata_o !== prev_d) begin
          errors++;
          $display("FAIL hold_stable: addr=%h data=%h required addr=%h data=%h",
                   addr_o, wdata_o, prev_a, prev_d);
        end
      end
      if (wvalid_o && wready) obs_q.push_back('{tgt: tgt_o, addr: addr_o, data: wdata_o});
      prev_v   = wvalid_o;
      prev_acc = wvalid_o && wready;
      prev_a   = addr_o;
      prev_d   = wdata_o;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sdi = b[i];
      #30 sck = 1'b1;
      #30 sck = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (6) @(negedge clk);
    while (busy_o !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout: busy_o=%b required 0", name, busy_o);
    end
    repeat (4) @(negedge clk);
  endtask

  // Sends cmd, 2-byte address, every entry of words, then `extra` stray bytes,
  // and checks the outcome against the frame-level model.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] a, input int extra,
                           input string name);
    wr_t         exp_q[$];
    logic [31:0] w, exp_sum;
    logic [2:0]  exp_err;
    bit          good;
    obs_q.delete();
    done_cnt = 0;
    rr_seen  = 1'b0;
    csb = 1'b0;
    #50;
    spi_byte(cmd);
    spi_byte(a[7:0]);
    spi_byte(a[15:8]);
    foreach (words[k]) begin
      w = words[k];
      for (int b = 0; b < 4; b++) spi_byte(w[8*b +: 8]);
    end
    for (int e = 0; e < extra; e++) spi_byte(8'($urandom));
    #50 csb = 1'b1;
    wait_idle(name);

    good    = (cmd[7:4] == 4'hB) && (cmd[3:0] < 2);
    exp_err = !good ? 3'b001 : (extra != 0) ? 3'b010 : 3'b000;
    exp_sum = 32'd0;
    if (good) begin
      foreach (words[k]) begin
        exp_q.push_back('{tgt: cmd[0:0], addr: 13'((int'(a) + k) % 8192), data: words[k]});
        exp_sum += words[k];
      end
    end
`ifndef SPI_LOADER_CHECKSUM_EN
    exp_sum = 32'd0;
`endif

    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].tgt !== exp_q[i].tgt || obs_q[i].addr !== exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL %s write%0d: got tgt=%0d addr=%h data=%h required tgt=%0d addr=%h data=%h",
                 name, i, obs_q[i].tgt, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].tgt, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (err_o !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b required %b", name, err_o, exp_err);
    end
    checks++;
    if (done_cnt != ((exp_err == 3'b000) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required %0d", name, done_cnt,
               (exp_err == 3'b000) ? 1 : 0);
    end
    checks++;
    if (rr_seen != good || reset_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_req: seen=%0d now=%b required seen=%0d now=0",
               name, rr_seen, reset_req_o, good);
    end
    checks++;
    if (checksum_o !== exp_sum) begin
      errors++;
      $display("FAIL %s checksum: got %h required %h", name, checksum_o, exp_sum);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    csb = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wvalid_o, busy_o, reset_req_o, done_o, err_o, tgt_o, addr_o, wdata_o, checksum_o} !== '0)
    begin
      errors++;
      $display("FAIL reset_outputs: wvalid=%b busy=%b rr=%b done=%b err=%b tgt=%0d addr=%h data=%h",
               wvalid_o, busy_o, reset_req_o, done_o, err_o, tgt_o, addr_o, wdata_o);
    end
    rst_i = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || wvalid_o !== 1'b0 || err_o !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy=%b wvalid=%b err=%b required 0 0 000",
               busy_o, wvalid_o, err_o);
    end
  endtask

  task automatic test_basic();
    ready_mode = 1;
    words = '{32'h11223344, 32'h55667788};
    run_frame(8'hB0, 16'h0010, 0, "basic");
  endtask

  task automatic test_wrap();
    words = '{$urandom, $urandom, $urandom};
    run_frame(8'hB1, 16'h1FFF, 0, "wrap");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int n;
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      cmd = {4'hB, 3'b000, 1'($urandom_range(0, 1))};
      n = $urandom_range(1, 4);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      run_frame(cmd, 16'($urandom), 0, "random");
    end
    ready_mode = 1;
  endtask

  task automatic test_bad_cmd();
    words = '{$urandom};
    run_frame(8'hB5, 16'h0000, 0, "bad_tgt");
    run_frame({4'($urandom_range(0, 10)), 4'h0}, 16'h0004, 0, "bad_prefix");
  endtask

  task automatic test_partial();
    words = '{$urandom};
    run_frame(8'hB0, 16'($urandom), 2, "partial");
  endtask

  task automatic test_checksum();
    words = '{32'hFFFF_FFFF, 32'h0000_0002};
    run_frame(8'hB1, 16'h0100, 0, "checksum");
  endtask

  task automatic test_overrun();
    logic [31:0] w1, w2;
    w1 = $urandom;
    w2 = $urandom;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    done_cnt = 0;
    csb = 1'b0;
    #50;
    spi_byte(8'hB0);
    spi_byte(8'h20);
    spi_byte(8'h00);
    for (int b = 0; b < 4; b++) spi_byte(w1[8*b +: 8]);
    for (int b = 0; b < 4; b++) spi_byte(w2[8*b +: 8]);
    #50 csb = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || wvalid_o !== 1'b1 || wdata_o !== w1 || addr_o !== 13'h0020) begin
      errors++;
      $display("FAIL overrun_hold: busy=%b wvalid=%b data=%h addr=%h required 1 1 %h 0020",
               busy_o, wvalid_o, wdata_o, addr_o, w1);
    end
    ready_mode = 1;
    wait_idle("overrun");
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== w1) begin
      errors++;
      $display("FAIL overrun_writes: count=%0d required 1 with data %h", obs_q.size(), w1);
    end
    checks++;
    if (err_o !== 3'b100 || done_cnt != 0) begin
      errors++;
      $display("FAIL overrun_err: err=%b done=%0d required 100 0", err_o, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = $urandom;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    csb = 1'b0;
    #50;
    spi_byte(8'hB1);
    spi_byte(8'h00);
    spi_byte(8'h01);
    for (int b = 0; b < 4; b++) spi_byte(w[8*b +: 8]);
    spi_byte(8'h5A);
    spi_byte(8'hC3);
    @(negedge clk);
    checks++;
    if (wvalid_o !== 1'b1 || wdata_o !== w) begin
      errors++;
      $display("FAIL midreset_pending: wvalid=%b data=%h required 1 %h", wvalid_o, wdata_o, w);
    end
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wvalid_o, busy_o, reset_req_o, done_o, err_o, tgt_o, addr_o, wdata_o, checksum_o} !== '0)
    begin
      errors++;
      $display("FAIL midreset_outputs: wvalid=%b busy=%b rr=%b err=%b addr=%h data=%h required 0",
               wvalid_o, busy_o, reset_req_o, err_o, addr_o, wdata_o);
    end
    csb = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b0;
    ready_mode = 1;
    repeat (8) @(negedge clk);
    words = '{$urandom};
    run_frame(8'hB0, 16'h0042, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_bad_cmd();
    test_partial();
    test_checksum();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
